// File: rtl/bpb_update_queue.sv
// bpb_update_queue
//   In-order queue of branch predictions made at fetch. Each entry remembers
//   which BPB entry predicted the branch ({idx, tag}) and the predicted
//   direction. When execute resolves the oldest branch, the head entry is
//   popped and a registered update is issued to the BPB the following cycle,
//   flagging whether the prediction was wrong. A wrong prediction also raises
//   a one-cycle mispredict and squashes every younger prediction in flight.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   stall                freezes all state and masks the update strobes
//   flush                discards all entries (ignored while stalled)
//   push, push_idx,
//   push_tag, push_taken new prediction from fetch
//   resolve,
//   resolve_taken        execute resolved the oldest branch, actual direction
//   upd_wen, upd_idx,
//   upd_tag, upd_taken,
//   upd_mistake          BPB update interface (valid one cycle after resolve)
//   mispredict           redirect request, same timing as upd_mistake
//   full, empty, count   occupancy
//   underflow            sticky: a resolve arrived while the queue was empty
module bpb_update_queue #(
  parameter int DEPTH     = 8,
  parameter int ENTRIES   = 16,
  parameter int TAG_WIDTH = 10,
  localparam int IDX_W    = $clog2(ENTRIES),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 push,
  input  logic [IDX_W-1:0]     push_idx,
  input  logic [TAG_WIDTH-1:0] push_tag,
  input  logic                 push_taken,
  input  logic                 resolve,
  input  logic                 resolve_taken,
  output logic                 upd_wen,
  output logic [IDX_W-1:0]     upd_idx,
  output logic [TAG_WIDTH-1:0] upd_tag,
  output logic                 upd_taken,
  output logic                 upd_mistake,
  output logic                 mispredict,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_W-1:0]     count,
  output logic                 underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [IDX_W-1:0]     idx_mem [DEPTH];
  logic [TAG_WIDTH-1:0] tag_mem [DEPTH];
  logic [DEPTH-1:0]     taken_mem;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  logic acc_push_p0;
  logic acc_resolve_p0;
  logic squash_p0;

  logic                 vld_p1;
  logic                 mistake_p1;
  logic [IDX_W-1:0]     idx_p1;
  logic [TAG_WIDTH-1:0] tag_p1;
  logic                 taken_p1;

  // ---- p0: accept decisions against the current head ----
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));
  assign count = cnt;

  always_comb begin
    acc_resolve_p0 = resolve & ~empty & ~stall & ~flush;
    squash_p0      = acc_resolve_p0 & (taken_mem[rd_ptr] ^ resolve_taken);
    // A full queue still takes a push when the head leaves in the same cycle;
    // a push racing a mispredict is younger than the bad branch and dies.
    acc_push_p0    = push & (~full | acc_resolve_p0) & ~stall & ~flush & ~squash_p0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      underflow <= 1'b0;
    end else if (!stall) begin
      if (flush || squash_p0) begin
        // Equalising the pointers empties the ring without touching storage.
        rd_ptr <= wr_ptr;
        cnt    <= '0;
      end else begin
        if (acc_push_p0)    wr_ptr <= wr_ptr + PTR_W'(1);
        if (acc_resolve_p0) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({acc_push_p0, acc_resolve_p0})
          2'b10:   cnt <= cnt + CNT_W'(1);
          2'b01:   cnt <= cnt - CNT_W'(1);
          default: cnt <= cnt;
        endcase
      end
      if (resolve && empty && !flush) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_push_p0) begin
      idx_mem[wr_ptr]   <= push_idx;
      tag_mem[wr_ptr]   <= push_tag;
      taken_mem[wr_ptr] <= push_taken;
    end
  end

  // ---- p1: registered BPB update ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      mistake_p1 <= 1'b0;
      idx_p1     <= '0;
      tag_p1     <= '0;
      taken_p1   <= 1'b0;
    end else begin
      vld_p1     <= acc_resolve_p0;
      mistake_p1 <= squash_p0;
      if (acc_resolve_p0) begin
        idx_p1   <= idx_mem[rd_ptr];
        tag_p1   <= tag_mem[rd_ptr];
        taken_p1 <= resolve_taken;
      end
    end
  end

  // Strobes are masked by the live stall; a masked update is not replayed.
  assign upd_wen     = vld_p1 & ~stall;
  assign upd_mistake = mistake_p1 & ~stall;
  assign mispredict  = upd_mistake;
  assign upd_idx     = idx_p1;
  assign upd_tag     = tag_p1;
  assign upd_taken   = taken_p1;

endmodule

// File: doc/bpb_update_queue.md
Name: bpb_update_queue

Overview:
- In-order FIFO of branch predictions issued at fetch, held until the execute stage resolves each branch.
- On resolution, compares the actual outcome with the stored prediction and drives the update interface of the branch prediction buffer entries: write enable, index, tag, actual direction and mistake.
- Raises a mispredict redirect and squashes all younger in-flight predictions.

Parameters:
- DEPTH, 8, number of in-flight prediction slots; power of two, at least 2.
- ENTRIES, 16, BPB entry count; index width is IDX_W = $clog2(ENTRIES).
- TAG_WIDTH, 10, width of the BPB entry tag.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  pipeline stall; freezes all state.
- flush  input  1  external pipeline flush; discards all entries.
- push  input  1  fetch issued a predicted branch this cycle.
- push_idx  input  IDX_W  BPB entry index used for the prediction.
- push_tag  input  TAG_WIDTH  tag of the predicting PC.
- push_taken  input  1  predicted direction.
- resolve  input  1  execute resolved the oldest branch this cycle.
- resolve_taken  input  1  actual direction.
- upd_wen  output  1  BPB update strobe.
- upd_idx  output  IDX_W  entry to update.
- upd_tag  output  TAG_WIDTH  real tag for the update.
- upd_taken  output  1  actual direction.
- upd_mistake  output  1  prediction was wrong.
- mispredict  output  1  redirect request, one-cycle pulse.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH+1)  occupied slots.
- underflow  output  1  sticky error: resolve while empty.

Behaviour:
- Reset (async): all slots invalid; read and write pointers 0; count 0; empty=1; full=0.
- Reset values of the remaining outputs: upd_wen, upd_mistake, mispredict and underflow all 0; upd_idx, upd_tag and upd_taken all 0.
- A reset asserted mid-operation discards every in-flight entry immediately.
- Storage: circular buffer, pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
- Accepted push: push & !full & !stall & !flush & !squash. Writes {idx, tag, taken} at the write pointer and increments it.
- Push while full: dropped, no state change.
- Accepted resolve: resolve & !empty & !stall & !flush. Pops the head entry.
- Update outputs: registered, valid the cycle after an accepted resolve. upd_wen=1 for exactly 1 cycle.
  - upd_idx and upd_tag come from the head entry.
  - upd_taken = resolve_taken.
  - upd_mistake = head.taken XOR resolve_taken.
- mispredict equals upd_mistake in the same cycle.
- squash is an internal signal, set combinationally when an accepted resolve mismatches.
  - In that cycle the queue clears: pointers equalised and count becomes 0 at the clock edge.
  - A push in the same cycle is discarded.
- Push and resolve in the same cycle, no mismatch: both take effect, count unchanged. This is legal when full: pop frees the slot, so push is accepted when full & accepted resolve & no mismatch.
- Resolve while empty (not stalled, not flushed): ignored, upd_wen stays 0, underflow set to 1 and held until reset.
- flush has priority over push and resolve: queue clears, no update is emitted for that cycle, and a resolve in that cycle is dropped.
- stall: no push, pop or flush takes effect. upd_wen, upd_mistake and mispredict are forced to 0 during stall. A pending registered update does not wait: it is issued the cycle after acceptance, and acceptance never happens under stall.
- count arithmetic: +1 on push only, -1 on pop only, 0 on both. Saturation cannot occur because of the accept rules.

Test Plan:
- Reset while 3 entries are held -> count=0, empty=1, upd_wen=0 immediately, without waiting for a clock.
- Push {idx=3, tag=0x2A5, taken=1}, then resolve taken=1 -> next cycle upd_wen=1, upd_idx=3, upd_tag=0x2A5, upd_taken=1, upd_mistake=0, mispredict=0, count=0.
- Push 3 entries with taken=0, then resolve the first with taken=1 -> upd_mistake=1 and mispredict=1 for 1 cycle, count=0; push in the resolve cycle is dropped.
- Fill 8 entries -> full=1. Extra push is dropped. Push and resolve together with no mismatch -> count stays 8, wrap to slot 0 is correct, and later pops return FIFO order.
- Resolve on empty -> no upd_wen, underflow=1 and still 1 after 10 cycles.
- stall held 4 cycles with push and resolve active -> count unchanged, upd_wen=0 throughout. flush together with resolve -> count=0, no update emitted.
